// File: rtl/sha_1_msg_padder.sv
// sha_1_msg_padder
//
// Byte-stream front-end for the sha_1 block engine. It gathers message bytes into
// a 64-byte block, appends SHA-1 padding (0x80 marker, zero fill and the 64-bit
// big-endian bit length), and hands each 512-bit block to the core with a
// start/done handshake. It holds every block stable until the core reports done.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   in_valid     in_byte is valid
//   in_ready     padder accepts a byte this cycle (FILL only)
//   in_byte      message byte, stream order
//   in_last      accepted byte is the final byte of the message
//   blk_data     512-bit block; word 0 = [31:0], byte 0 = word0[31:24]
//   blk_start    one-cycle pulse, blk_data valid and stable until core_done
//   blk_first    block is the first of its message (valid with blk_start)
//   core_done    core finished the current block (pulse)
//   msg_done     one-cycle pulse after core_done of the message's final block
//
// Optional build macro SHA_1_MSG_PADDER_DIGEST_EN adds:
//   core_digest  160-bit digest from the core
//   digest       digest latched on core_done of the final block (reset 0)

module sha_1_msg_padder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic [511:0] blk_data,
    output logic         blk_start,
    output logic         blk_first,
    input  logic         core_done,
    output logic         msg_done
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
    ,
    input  logic [159:0] core_digest,
    output logic [159:0] digest
`endif
);

    typedef enum logic [2:0] {StFill, StPad, StLen, StIssue, StWait} state_e;

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [511:0]  buf_q, buf_d;
    logic [5:0]    ptr_q, ptr_d;
    logic [60:0]   nbytes_q, nbytes_d;
    logic          final_q, final_d;
    logic          first_q, first_d;
    // Buffer holds a complete 64-byte last block that still needs issuing.
    logic          full_q, full_d;
    logic          in_ready_q, in_ready_d;
    logic          blk_start_q, blk_start_d;
    logic          blk_first_q, blk_first_d;
    logic          msg_done_q, msg_done_d;
    logic [8:0]    lo;
    logic [63:0]   bit_len;

    // Bit offset of the byte at ptr: word ptr[5:2], big-endian byte within the word.
    assign lo      = {ptr_q[5:2], 5'b0} + {4'b0, ~ptr_q[1:0], 3'b0};
    assign bit_len = {nbytes_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        buf_d    = buf_q;
        ptr_d    = ptr_q;
        nbytes_d = nbytes_q;
        final_d  = final_q;
        first_d  = first_q;
        full_d   = full_q;
        msg_done_d = 1'b0;

        unique case (state_q)
            StFill: begin
                if (in_valid && in_ready_q) begin
                    buf_d[lo +: 8] = in_byte;
                    ptr_d          = ptr_q + 6'd1;
                    nbytes_d       = nbytes_q + 61'd1;
                    if (ptr_q == 6'd63) full_d = 1'b1;
                    if (in_last) begin
                        state_d = StPad;
                    end else if (ptr_q == 6'd63) begin
                        ret_d   = StFill;
                        state_d = StIssue;
                    end
                end
            end
            StPad: begin
                if (full_q) begin
                    ret_d   = StPad;
                    state_d = StIssue;
                end else begin
                    buf_d[lo +: 8] = 8'h80;
                    ptr_d          = ptr_q + 6'd1;
                    if (ptr_q <= 6'd55) begin
                        state_d = StLen;
                    end else begin
                        ret_d   = StLen;
                        state_d = StIssue;
                    end
                end
            end
            StLen: begin
                buf_d[14*32 +: 32] = bit_len[63:32];
                buf_d[15*32 +: 32] = bit_len[31:0];
                final_d            = 1'b1;
                state_d            = StIssue;
            end
            StIssue: begin
                first_d = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                if (core_done) begin
                    buf_d  = '0;
                    ptr_d  = '0;
                    full_d = 1'b0;
                    if (final_q) begin
                        msg_done_d = 1'b1;
                        nbytes_d   = '0;
                        final_d    = 1'b0;
                        first_d    = 1'b1;
                        state_d    = StFill;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            default: state_d = StFill;
        endcase

        // Registered outputs track the state being entered.
        blk_start_d = (state_d == StIssue) && (state_q != StIssue);
        blk_first_d = blk_start_d && first_q;
        in_ready_d  = (state_d == StFill);
    end

`ifdef SHA_1_MSG_PADDER_DIGEST_EN
    logic [159:0] digest_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digest_q <= '0;
        end else if (state_q == StWait && core_done && final_q) begin
            digest_q <= core_digest;
        end
    end
    assign digest = digest_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StFill;
            ret_q       <= StFill;
            buf_q       <= '0;
            ptr_q       <= '0;
            nbytes_q    <= '0;
            final_q     <= 1'b0;
            first_q     <= 1'b1;
            full_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_start_q <= 1'b0;
            blk_first_q <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            buf_q       <= buf_d;
            ptr_q       <= ptr_d;
            nbytes_q    <= nbytes_d;
            final_q     <= final_d;
            first_q     <= first_d;
            full_q      <= full_d;
            in_ready_q  <= in_ready_d;
            blk_start_q <= blk_start_d;
            blk_first_q <= blk_first_d;
            msg_done_q  <= msg_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_data  = buf_q;
    assign blk_start = blk_start_q;
    assign blk_first = blk_first_q;
    assign msg_done  = msg_done_q;

endmodule

// File: tb/tb_sha_1_msg_padder.sv
// Self-checking bench for sha_1_msg_padder: a byte driver and a core responder run
// in parallel; expected blocks come from a padded-byte reference model.

module tb_sha_1_msg_padder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic [511:0] blk_data;
    logic         blk_start;
    logic         blk_first;
    logic         core_done;
    logic         msg_done;
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
    logic [159:0] core_digest;
    logic [159:0] digest;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] msg_q[$];

    always #5 clk = ~clk;

    sha_1_msg_padder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .blk_data  (blk_data),
        .blk_start (blk_start),
        .blk_first (blk_first),
        .core_done (core_done),
        .msg_done  (msg_done)
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
        ,
        .core_digest (core_digest),
        .digest      (digest)
`endif
    );

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; core_done = 1'b0;
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
        core_digest = '0;
`endif
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fails++;
            $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (blk_start !== 1'b0 || blk_first !== 1'b0 || msg_done !== 1'b0) begin
            n_fails++; $display("FAIL reset_pulses got %b%b%b want 000",
                                blk_start, blk_first, msg_done); end
        n_checks++; if (blk_data !== 512'h0) begin n_fails++;
            $display("FAIL reset_blk_data got %h want 0", blk_data); end
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
        n_checks++; if (digest !== 160'h0) begin n_fails++;
            $display("FAIL reset_digest got %h want 0", digest); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fails++;
            $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    // Drives msg_q through the DUT while a responder acts as the sha_1 core and
    // checks every block against the padded-message model. Starts on a negedge.
    task automatic run_msg(input bit gaps);
        logic [7:0]  pad[$];
        logic [63:0] bit_len;
        int          n;
        int          nblk;
        n = msg_q.size();
        pad = msg_q;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bit_len = 64'(n) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(bit_len[8*k +: 8]);
        nblk = pad.size() / 64;
        fork
            begin : driver
                for (int i = 0; i < n; i++) begin
                    int budget;
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    in_valid = 1'b1; in_byte = msg_q[i]; in_last = (i == n - 1);
                    budget = 0;
                    while (in_ready !== 1'b1 && budget < 2000) begin
                        @(negedge clk); budget++;
                    end
                    if (budget >= 2000) begin
                        n_checks++; n_fails++;
                        $display("FAIL in_ready_timeout byte %0d got 0 want 1", i);
                        break;
                    end
                    @(negedge clk);
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin : responder
                for (int b = 0; b < nblk; b++) begin
                    logic [511:0] exp;
                    int budget;
                    logic [159:0] dg;
                    for (int k = 0; k < 64; k++)
                        exp[(k / 4) * 32 + 24 - 8 * (k % 4) +: 8] = pad[b * 64 + k];
                    budget = 0;
                    while (blk_start !== 1'b1 && budget < 2000) begin
                        @(negedge clk); budget++;
                    end
                    n_checks++;
                    if (budget >= 2000) begin
                        n_fails++;
                        $display("FAIL blk_start_timeout len %0d blk %0d got 0 want 1", n, b);
                        break;
                    end
                    n_checks++; if (blk_data !== exp) begin n_fails++;
                        $display("FAIL blk_data len %0d blk %0d got %h want %h",
                                 n, b, blk_data, exp); end
                    n_checks++; if (blk_first !== (b == 0)) begin n_fails++;
                        $display("FAIL blk_first len %0d blk %0d got %b want %b",
                                 n, b, blk_first, b == 0); end
                    n_checks++; if (in_ready !== 1'b0) begin n_fails++;
                        $display("FAIL in_ready_while_busy len %0d blk %0d got 1 want 0", n, b);
                    end
                    repeat ($urandom_range(1, 5)) @(negedge clk);
                    n_checks++; if (blk_data !== exp || blk_start !== 1'b0) begin n_fails++;
                        $display("FAIL blk_hold len %0d blk %0d got %h/%b want %h/0",
                                 n, b, blk_data, blk_start, exp); end
                    dg = {$urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
                    core_digest = dg;
`endif
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                    n_checks++; if (msg_done !== (b == nblk - 1)) begin n_fails++;
                        $display("FAIL msg_done len %0d blk %0d got %b want %b",
                                 n, b, msg_done, b == nblk - 1); end
                    if (b == nblk - 1) begin
                        n_checks++; if (in_ready !== 1'b1) begin n_fails++;
                            $display("FAIL in_ready_after_done len %0d got 0 want 1", n); end
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
                        n_checks++; if (digest !== dg) begin n_fails++;
                            $display("FAIL digest len %0d got %h want %h", n, digest, dg); end
`endif
                    end
                end
            end
        join
    endtask

    task automatic test_abc();
        logic [511:0] exp;
        logic [7:0]   abc[3];
        abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
        exp = '0;
        exp[31:0]    = 32'h61626380;
        exp[511:480] = 32'h00000018;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_byte = abc[i]; in_last = (i == 2);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++; if (blk_start !== 1'b0) begin n_fails++;
            $display("FAIL abc_latency_t1 got %b want 0", blk_start); end
        @(negedge clk);
        n_checks++; if (blk_start !== 1'b0) begin n_fails++;
            $display("FAIL abc_latency_t2 got %b want 0", blk_start); end
        @(negedge clk);
        n_checks++; if (blk_start !== 1'b1) begin n_fails++;
            $display("FAIL abc_latency_t3 got %b want 1", blk_start); end
        n_checks++; if (blk_data !== exp) begin n_fails++;
            $display("FAIL abc_block got %h want %h", blk_data, exp); end
        n_checks++; if (blk_first !== 1'b1) begin n_fails++;
            $display("FAIL abc_first got %b want 1", blk_first); end
        repeat (2) @(negedge clk);
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
        core_digest = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
`endif
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n_checks++; if (msg_done !== 1'b1 || in_ready !== 1'b1) begin n_fails++;
            $display("FAIL abc_msg_done got %b/%b want 1/1", msg_done, in_ready); end
`ifdef SHA_1_MSG_PADDER_DIGEST_EN
        n_checks++;
        if (digest !== 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D) begin n_fails++;
            $display("FAIL abc_digest got %h", digest); end
`endif
        @(negedge clk);
        n_checks++; if (msg_done !== 1'b0) begin n_fails++;
            $display("FAIL abc_msg_done_pulse got %b want 0", msg_done); end
    endtask

    task automatic test_lengths();
        int lens[9] = '{55, 56, 64, 1, 63, 65, 119, 120, 128};
        foreach (lens[j]) begin
            msg_q.delete();
            for (int i = 0; i < lens[j]; i++) msg_q.push_back(8'($urandom));
            run_msg(1'b0);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int len;
            len = int'($urandom_range(1, 200));
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            run_msg(1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            msg_q.delete();
            for (int i = 0; i < 4 + j; i++) msg_q.push_back(8'($urandom));
            run_msg(1'b0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int budget;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_byte = 8'($urandom); in_last = (i == 9);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        budget = 0;
        while (blk_start !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
        n_checks++; if (budget >= 100) begin n_fails++;
            $display("FAIL midwait_start got 0 want 1"); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (blk_data !== 512'h0 || in_ready !== 1'b0 || blk_start !== 1'b0 ||
            blk_first !== 1'b0 || msg_done !== 1'b0) begin
            n_fails++;
            $display("FAIL midwait_reset got data %h ready %b start %b first %b done %b want 0",
                     blk_data, in_ready, blk_start, blk_first, msg_done);
        end
        reset_n = 1'b1;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (msg_done !== 1'b0 || blk_start !== 1'b0 || in_ready !== 1'b1) begin
                n_fails++;
                $display("FAIL stray_done cycle %0d got done %b start %b ready %b want 0/0/1",
                         i, msg_done, blk_start, in_ready);
            end
            @(negedge clk);
        end
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        run_msg(1'b0);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_lengths();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
